floo_dummy_endpoint: RTL



---
 rtl/floo_dummy_endpoint.sv | 117 +++++++++++
 1 files changed

// File: rtl/floo_dummy_endpoint.sv
// Dummy NoC endpoint: per-channel drop / loopback (src/dst swapped) / stall
// with saturating rx/tx flit counters and FIFO occupancy reporting.
module floo_dummy_endpoint #(
    parameter int unsigned NumChannels = 3,
    parameter int unsigned FlitWidth   = 64,
    parameter int unsigned IdWidth     = 6,
    parameter int unsigned DstLsb      = 0,
    parameter int unsigned SrcLsb      = 6,
    parameter int unsigned FifoDepth   = 4,
    parameter int unsigned CntWidth    = 16
) (
    input  logic                                           clk_i,
    input  logic                                           rst_ni,
    input  logic [2*NumChannels-1:0]                       mode_i,
    input  logic [NumChannels-1:0]                         clear_i,
    input  logic [NumChannels-1:0]                         in_valid_i,
    output logic [NumChannels-1:0]                         in_ready_o,
    input  logic [NumChannels*FlitWidth-1:0]               in_data_i,
    output logic [NumChannels-1:0]                         out_valid_o,
    input  logic [NumChannels-1:0]                         out_ready_i,
    output logic [NumChannels*FlitWidth-1:0]               out_data_o,
    output logic [NumChannels*CntWidth-1:0]                rx_cnt_o,
    output logic [NumChannels*CntWidth-1:0]                tx_cnt_o,
    output logic [NumChannels*$clog2(FifoDepth+1)-1:0]     fill_o
);

    localparam int unsigned FillWidth = $clog2(FifoDepth + 1);
    localparam int unsigned PtrWidth  = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

    typedef enum logic [1:0] {
        MODE_DROP  = 2'd0,
        MODE_LOOP  = 2'd1,
        MODE_STALL = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    // Clear first, then count the coinciding event; hold at all-ones.
    function automatic logic [CntWidth-1:0] cnt_next(input logic [CntWidth-1:0] cnt,
                                                     input logic clr, input logic ev);
        logic [CntWidth-1:0] base;
        base = clr ? '0 : cnt;
        if (ev && (base != '1)) base = base + CntWidth'(1);
        return base;
    endfunction

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
        return (ptr == PtrWidth'(FifoDepth - 1)) ? '0 : ptr + PtrWidth'(1);
    endfunction

    for (genvar c = 0; c < NumChannels; c++) begin : g_chan
        logic [FlitWidth-1:0] mem [FifoDepth];
        logic [PtrWidth-1:0]  rd_ptr, wr_ptr;
        logic [FillWidth-1:0] fill;
        logic [CntWidth-1:0]  rx_cnt, tx_cnt;
        logic [FlitWidth-1:0] in_data, swapped;
        logic                 ready, accept, push, pop, not_empty;
        mode_e                mode;

        assign mode      = mode_e'(mode_i[2*c +: 2]);
        assign in_data   = in_data_i[c*FlitWidth +: FlitWidth];
        assign not_empty = (fill != '0);

        // Readiness depends only on mode and registered occupancy, never on the
        // same-cycle pop, so a full FIFO refuses a push even while draining.
        always_comb begin
            ready = 1'b0;
            case (mode)
                MODE_DROP: ready = 1'b1;
                MODE_LOOP: ready = (fill != FillWidth'(FifoDepth));
                default:   ready = 1'b0;
            endcase
            ready = ready & rst_ni;
        end

        always_comb begin
            swapped                      = in_data;
            swapped[DstLsb +: IdWidth]   = in_data[SrcLsb +: IdWidth];
            swapped[SrcLsb +: IdWidth]   = in_data[DstLsb +: IdWidth];
        end

        assign accept = in_valid_i[c] & ready;
        assign push   = accept & (mode == MODE_LOOP);
        assign pop    = not_empty & out_ready_i[c];

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                for (int unsigned i = 0; i < FifoDepth; i++) mem[i] <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
                fill   <= '0;
                rx_cnt <= '0;
                tx_cnt <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= swapped;
                    wr_ptr      <= ptr_inc(wr_ptr);
                end
                if (pop) rd_ptr <= ptr_inc(rd_ptr);
                case ({push, pop})
                    2'b10:   fill <= fill + FillWidth'(1);
                    2'b01:   fill <= fill - FillWidth'(1);
                    default: fill <= fill;
                endcase
                rx_cnt <= cnt_next(rx_cnt, clear_i[c], accept);
                tx_cnt <= cnt_next(tx_cnt, clear_i[c], pop);
            end
        end

        assign in_ready_o[c]                       = ready;
        assign out_valid_o[c]                      = not_empty;
        assign out_data_o[c*FlitWidth +: FlitWidth] = mem[rd_ptr];
        assign rx_cnt_o[c*CntWidth +: CntWidth]     = rx_cnt;
        assign tx_cnt_o[c*CntWidth +: CntWidth]     = tx_cnt;
        assign fill_o[c*FillWidth +: FillWidth]     = fill;
    end

endmodule
